spi_resp: RTL and testbench
===========================

# spi_resp

Synthesizable SPI responder: the chip-side end of the ADC SPI link, driven by the team's ADC SPI master. Accepts a 16-bit command on `mosi` per `cs` frame and returns a 32-bit response double-data-rate on `miso`: word A bits on sclk rising edges, word B bits on sclk falling edges. Used as an ADC chip emulator for loopback bring-up and as the bench responder for the master. It oversamples all SPI pins in its own `clk` domain.

## Interface
- No parameters.
- `clk`  in  1  system clock; must be ≥4× the SPI master's clock.
- `rst`  in  1  asynchronous, active-low reset (`rst`=0 resets).
- `cs`  in  1  chip select, active low, asynchronous to `clk`.
- `sclk`  in  1  SPI clock, idle low, asynchronous to `clk`.
- `mosi`  in  1  command bit, MSB first.
- `miso`  out  1  response bit.
- `rsp_txd`  in  32  response word; [31:16]=A, [15:0]=B; latched once per frame.
- `cmd_rxd`  out  16  last correctly received command.
- `cmd_vld`  out  1  one-cycle pulse: `cmd_rxd` updated.
- `frm_err`  out  1  one-cycle pulse: frame closed with ≠16 rising edges.
- `busy`  out  1  high from frame start until frame close.

## Operation
- Synchronizers: `cs`, `sclk`, `mosi` each pass through 2 flops, then one history flop for edge detection. All logic uses synchronized values only.
- State machine:
  - IDLE: waits for a synchronized `cs` falling edge. Level low alone never starts a frame.
  - LOAD: one cycle; latches `rsp_txd` into a 32-bit shift register; clears the bit counter and `ovf`; `busy`=1.
  - SHFT:
    - On sclk rising edge: shift synchronized `mosi` into the command shifter (MSB first); drive `miso` ← A bit 15−n; increment counter n (5 bits, saturates at 17, sets `ovf` on the 17th edge).
    - On sclk falling edge with n in 1..16: drive `miso` ← B bit 16−n.
    - On `cs` rising edge: go to DONE.
  - DONE: one cycle.
    - If n==16 and !`ovf`: `cmd_rxd` ← shifter and `cmd_vld`=1.
    - Otherwise: `frm_err`=1 and `cmd_rxd` unchanged.
    - Then `busy`=0, `miso`=0, go to IDLE.
- Same-cycle sclk edge and `cs` rise: `cs` rise wins; the sclk edge is ignored.
- `rsp_txd` changes after LOAD do not affect the current frame.
- `miso` is 0 whenever not in SHFT, and 0 in SHFT before the first rising edge.
- sclk edges seen while in IDLE are ignored.
- Reset mid-frame: all state clears immediately.
  - After release with `cs` still low, the block stays in IDLE until `cs` goes high and then low again.
  - The aborted frame produces no `cmd_vld` and no `frm_err`.
- Reset values: `miso`=0, `cmd_rxd`=16'h0000, `cmd_vld`=0, `frm_err`=0, `busy`=0, state IDLE.

## Timing
- Pin edge to detection: the edge is seen in the 3rd `clk` cycle after the pin changes (2 sync flops + history flop).
- `miso` is registered and updates on the `clk` edge after detection, i.e. ≤4 `clk` cycles after the sclk pin edge. This must fit inside the master's 2-cycle sclk high/low phase, which is why `clk` ≥4× master clock.
- `busy` rises 1 cycle after the `cs` fall is detected (LOAD).
- `cmd_vld` / `frm_err` is high for exactly 1 cycle, 1 cycle after the `cs` rise is detected. `cmd_rxd` is valid in the same cycle as `cmd_vld`.
- Back-to-back frames:
  - `cs` high for ≥3 `clk` cycles is guaranteed to be detected.
  - A new `cs` fall arriving while in DONE is held in the edge history and handled in IDLE on the next cycle.
  - No frame is dropped if `cs` is high ≥2 master clocks.

## Test plan
- Full frame, master sends 16'hE83F, `rsp_txd`=32'h1234ABCD → `cmd_rxd`=16'hE83F with one `cmd_vld` pulse; master `chip_rxd`=32'h1234ABCD; `frm_err` stays 0.
- Short frame (`cs` raised after 8 rising edges) → one `frm_err` pulse, no `cmd_vld`, `cmd_rxd` keeps its previous value, `miso`=0 after close.
- Long frame (17 rising edges) → `frm_err` pulse, no `cmd_vld`.
- Reset asserted at rising edge 5, released with `cs` low, remaining edges applied → outputs all 0, no pulses. Next full frame with 16'h0001 / 32'h0000FFFF is received correctly.
- Two back-to-back frames, `cs` high 10 master clocks, `rsp_txd` 32'hAAAA5555 then 32'h0F0F_F0F0, `rsp_txd` toggled mid-frame → each frame returns its own word latched at LOAD; two `cmd_vld` pulses.
- `cs` and final sclk edge in the same `clk` cycle → frame closes with the edge ignored: 15 edges gives `frm_err`, 16 edges gives `cmd_vld`.

Source files
------------

// File: rtl/spi_resp_if.sv
`default_nettype none
// ============================================================================
// Module : spi_resp_if
// Pin and data bundle between an ADC SPI master and the spi_resp responder.
// Rev    : 1.0
// ============================================================================
interface spi_resp_if;
  logic        cs;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic [31:0] rsp_txd;
  logic [15:0] cmd_rxd;
  logic        cmd_vld;
  logic        frm_err;
  logic        busy;

  modport slave (
    input  cs, sclk, mosi, rsp_txd,
    output miso, cmd_rxd, cmd_vld, frm_err, busy
  );

  modport master (
    output cs, sclk, mosi, rsp_txd,
    input  miso, cmd_rxd, cmd_vld, frm_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/spi_resp.sv
`default_nettype none
// ============================================================================
// Module : spi_resp
// SPI responder: 16-bit command in, 32-bit DDR response out, oversampled in clk.
// Rev    : 1.0
// ============================================================================
module spi_resp (
  input  logic       clk,
  input  logic       rst,
  spi_resp_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SHFT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;

  logic        cs_s1_q, cs_s2_q, cs_h_q, cs_h_d;
  logic        sclk_s1_q, sclk_s2_q, sclk_h_q;
  logic        mosi_s1_q, mosi_s2_q;

  logic [31:0] rsp_q, rsp_d;
  logic [15:0] cmd_sh_q, cmd_sh_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        miso_q, miso_d;
  logic [15:0] cmd_rxd_q, cmd_rxd_d;
  logic        cmd_vld_q, cmd_vld_d;
  logic        frm_err_q, frm_err_d;
  logic        busy_q, busy_d;

  logic        cs_fall, cs_rise, sclk_rise, sclk_fall;

  assign cs_fall   =  cs_h_q   & ~cs_s2_q;
  assign cs_rise   = ~cs_h_q   &  cs_s2_q;
  assign sclk_rise = ~sclk_h_q &  sclk_s2_q;
  assign sclk_fall =  sclk_h_q & ~sclk_s2_q;

  always_comb begin
    state_d   = state_q;
    cs_h_d    = cs_s2_q;
    rsp_d     = rsp_q;
    cmd_sh_d  = cmd_sh_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    miso_d    = miso_q;
    cmd_rxd_d = cmd_rxd_q;
    cmd_vld_d = 1'b0;
    frm_err_d = 1'b0;
    busy_d    = busy_q;

    case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        busy_d = 1'b0;
        if (cs_fall) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
        end
      end

      S_LOAD: begin
        rsp_d    = bus.rsp_txd;
        cmd_sh_d = 16'h0000;
        cnt_d    = 5'd0;
        ovf_d    = 1'b0;
        miso_d   = 1'b0;
        // A frame closed before any shifting can start is simply a zero-edge frame.
        if (cs_rise) begin
          state_d   = S_DONE;
          frm_err_d = 1'b1;
          busy_d    = 1'b0;
        end else begin
          state_d = S_SHFT;
        end
      end

      S_SHFT: begin
        // cs rise outranks any sclk edge seen in the same cycle.
        if (cs_rise) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          miso_d  = 1'b0;
          if ((cnt_q == 5'd16) && !ovf_q) begin
            cmd_rxd_d = cmd_sh_q;
            cmd_vld_d = 1'b1;
          end else begin
            frm_err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          cmd_sh_d = {cmd_sh_q[14:0], mosi_s2_q};
          miso_d   = (cnt_q < 5'd16) ? rsp_q[5'd31 - cnt_q] : 1'b0;
          if (cnt_q != 5'd17) begin
            cnt_d = cnt_q + 5'd1;
          end
          if (cnt_q == 5'd16) begin
            ovf_d = 1'b1;
          end
        end else if (sclk_fall && (cnt_q >= 5'd1) && (cnt_q <= 5'd16)) begin
          miso_d = rsp_q[5'd16 - cnt_q];
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        miso_d  = 1'b0;
        busy_d  = 1'b0;
        // Freeze cs history so a fall arriving now is still seen as an edge in IDLE.
        cs_h_d  = cs_h_q;
      end

      default: begin
        state_d = S_IDLE;
        miso_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // cs chain clears low so a still-low cs after reset never looks like a new frame.
      cs_s1_q   <= 1'b0;
      cs_s2_q   <= 1'b0;
      cs_h_q    <= 1'b0;
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_h_q  <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      state_q   <= S_IDLE;
      rsp_q     <= 32'h0000_0000;
      cmd_sh_q  <= 16'h0000;
      cnt_q     <= 5'd0;
      ovf_q     <= 1'b0;
      miso_q    <= 1'b0;
      cmd_rxd_q <= 16'h0000;
      cmd_vld_q <= 1'b0;
      frm_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      cs_s1_q   <= bus.cs;
      cs_s2_q   <= cs_s1_q;
      cs_h_q    <= cs_h_d;
      sclk_s1_q <= bus.sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_h_q  <= sclk_s2_q;
      mosi_s1_q <= bus.mosi;
      mosi_s2_q <= mosi_s1_q;
      state_q   <= state_d;
      rsp_q     <= rsp_d;
      cmd_sh_q  <= cmd_sh_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      miso_q    <= miso_d;
      cmd_rxd_q <= cmd_rxd_d;
      cmd_vld_q <= cmd_vld_d;
      frm_err_q <= frm_err_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.miso    = miso_q;
  assign bus.cmd_rxd = cmd_rxd_q;
  assign bus.cmd_vld = cmd_vld_q;
  assign bus.frm_err = frm_err_q;
  assign bus.busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_resp.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_resp
// Bit-banged SPI master driving spi_resp, checked against a frame-level model.
// Rev    : 1.0
// ============================================================================
module tb_spi_resp;

  logic clk;
  logic rst;

  spi_resp_if bus ();

  spi_resp dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          vld_cnt = 0;
  int          err_cnt = 0;
  int          wide_cnt = 0;
  logic        prev_vld = 1'b0;
  logic        prev_err = 1'b0;
  logic [15:0] last_vld_cmd = 16'h0000;
  logic [15:0] model_cmd = 16'h0000;

  always @(negedge clk) begin
    if (bus.cmd_vld) begin
      vld_cnt++;
      last_vld_cmd = bus.cmd_rxd;
    end
    if (bus.frm_err) err_cnt++;
    if ((bus.cmd_vld && prev_vld) || (bus.frm_err && prev_err) || (bus.cmd_vld && bus.frm_err))
      wide_cnt++;
    prev_vld = bus.cmd_vld;
    prev_err = bus.frm_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One master frame: nedges counted rising edges, optional extra edge coincident
  // with cs rise, optional reset pulse during rising edge rst_at, optional rsp_txd change.
  task automatic run_frame(input logic [15:0] cmd, input logic [31:0] rsp, input int nedges,
                           input bit coincide, input int rst_at, input bit toggle);
    logic [31:0] rx, exp_rx, mask;
    int          vld0, err0;
    bit          exp_vld, exp_err;
    vld0 = vld_cnt;
    err0 = err_cnt;
    rx = 32'h0;
    exp_rx = 32'h0;
    mask = 32'h0;
    bus.rsp_txd = rsp;
    bus.cs = 1'b0;
    tick(8);
    chk("busy_in_frame", {31'h0, bus.busy}, 32'h1);
    for (int i = 0; i < nedges; i++) begin
      bus.mosi = (i < 16) ? cmd[15-i] : 1'($urandom);
      tick(8);
      bus.sclk = 1'b1;
      if (i == rst_at) begin
        tick(2); rst = 1'b0; tick(3); rst = 1'b1; tick(2);
      end else begin
        tick(7);
      end
      @(negedge clk);
      if (i < 16) rx[31-i] = bus.miso;
      tick(1);
      if (toggle && i == 7) bus.rsp_txd = $urandom;
      bus.sclk = 1'b0;
      tick(7);
      @(negedge clk);
      if (i < 16) rx[15-i] = bus.miso;
      tick(1);
    end
    tick(8);
    if (coincide) begin
      bus.sclk = 1'b1;
      bus.cs = 1'b1;
      tick(8);
      bus.sclk = 1'b0;
    end else begin
      bus.cs = 1'b1;
    end
    tick(40);

    // Frame-level expectations
    exp_vld = (rst_at < 0) && (nedges == 16);
    exp_err = (rst_at < 0) && (nedges != 16);
    for (int i = 0; i < nedges && i < 16; i++) begin
      mask[31-i] = 1'b1;
      mask[15-i] = 1'b1;
      if (rst_at < 0 || i < rst_at) begin
        exp_rx[31-i] = rsp[31-i];
        exp_rx[15-i] = rsp[15-i];
      end
    end
    if (exp_vld) model_cmd = cmd;
    if (rst_at >= 0) model_cmd = 16'h0000;

    chk("chip_rxd", rx & mask, exp_rx);
    chk("vld_pulses", vld_cnt - vld0, {31'h0, exp_vld});
    chk("err_pulses", err_cnt - err0, {31'h0, exp_err});
    chk("cmd_rxd", {16'h0, bus.cmd_rxd}, {16'h0, model_cmd});
    if (exp_vld) chk("cmd_at_vld", {16'h0, last_vld_cmd}, {16'h0, cmd});
    chk("miso_after", {31'h0, bus.miso}, 32'h0);
    chk("busy_after", {31'h0, bus.busy}, 32'h0);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    bus.cs = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.rsp_txd = 32'h0;
    tick(3);
    chk("rst_miso", {31'h0, bus.miso}, 32'h0);
    chk("rst_cmd_rxd", {16'h0, bus.cmd_rxd}, 32'h0);
    chk("rst_cmd_vld", {31'h0, bus.cmd_vld}, 32'h0);
    chk("rst_frm_err", {31'h0, bus.frm_err}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    rst = 1'b1;
    tick(10);

    run_frame(16'hE83F, 32'h1234ABCD, 16, 1'b0, -1, 1'b0);
    run_frame(16'h5A5A, 32'hCAFEF00D, 8,  1'b0, -1, 1'b0);
    run_frame(16'h1357, 32'h89ABCDEF, 17, 1'b0, -1, 1'b0);
    run_frame(16'hBEEF, 32'hDEADBEEF, 16, 1'b0, 4,  1'b0);
    run_frame(16'h0001, 32'h0000FFFF, 16, 1'b0, -1, 1'b0);
    run_frame(16'hC3A5, 32'hAAAA5555, 16, 1'b0, -1, 1'b1);
    run_frame(16'h7E81, 32'h0F0FF0F0, 16, 1'b0, -1, 1'b1);
    run_frame(16'h2468, 32'h11223344, 15, 1'b1, -1, 1'b0);
    run_frame(16'h9BDF, 32'h55667788, 16, 1'b1, -1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      n = (k % 2 == 1) ? 16 : int'($urandom_range(1, 20));
      run_frame(16'($urandom), $urandom, n, 1'b0, -1, 1'b0);
    end

    chk("pulse_width", wide_cnt, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
